// File: rtl/scaler_bank_loader.sv
// rtl/scaler_bank_loader.sv - per-layer channel scaler fetch from ROM into a held output vector
module scaler_bank_loader #(
  parameter int DATA_W  = 32,
  parameter int NUM_CH  = 4,
  parameter int LAYER_W = 4,
  parameter int ADDR_W  = 6
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     run,
  input  logic                     reload,
  input  logic [LAYER_W-1:0]       layer_idx,
  output logic                     mem_en,
  output logic [ADDR_W-1:0]        mem_addr,
  input  logic [DATA_W-1:0]        mem_dout,
  output logic [NUM_CH*DATA_W-1:0] scaler_vec,
  output logic                     scaler_valid,
  output logic                     busy
);

  // Channel index width; a single-channel bank still needs one bit.
  localparam int K_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [K_W-1:0] K_LAST = K_W'(NUM_CH - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, READY} state_t;

  state_t             state, state_nxt;
  logic [ADDR_W-1:0]  base, base_nxt;
  logic [ADDR_W-1:0]  addr_nxt;
  logic [ADDR_W-1:0]  start_base;
  logic [K_W-1:0]     k, k_nxt;
  logic [K_W-1:0]     k_d;
  logic               en_d;
  logic               en_nxt;
  logic               valid_nxt;
  logic               busy_nxt;
  logic               capture_last;
  logic               start_fetch;

  // First ROM address of a layer's block; the product wraps to the ROM size.
  function automatic logic [ADDR_W-1:0] layer_base(input logic [LAYER_W-1:0] idx);
    return ADDR_W'(32'(idx) * 32'(NUM_CH));
  endfunction

  assign start_base   = layer_base(layer_idx);
  assign capture_last = en_d && (k_d == K_LAST);

  // Next-state and next registered-output decode; dropping run beats everything.
  always_comb begin
    state_nxt   = state;
    base_nxt    = base;
    k_nxt       = k;
    en_nxt      = 1'b0;
    addr_nxt    = mem_addr;
    valid_nxt   = scaler_valid;
    busy_nxt    = busy;
    start_fetch = 1'b0;

    if (!run) begin
      state_nxt = IDLE;
      valid_nxt = 1'b0;
      busy_nxt  = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          start_fetch = 1'b1;
        end
        FETCH: begin
          if (k == K_LAST) begin
            state_nxt = DRAIN;
          end else begin
            k_nxt    = k + K_W'(1);
            en_nxt   = 1'b1;
            addr_nxt = base + ADDR_W'(k_nxt);
          end
        end
        DRAIN: begin
          if (capture_last) begin
            state_nxt = READY;
            valid_nxt = 1'b1;
            busy_nxt  = 1'b0;
          end
        end
        READY: begin
          if (reload) begin
            start_fetch = 1'b1;
          end
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase

      if (start_fetch) begin
        state_nxt = FETCH;
        base_nxt  = start_base;
        k_nxt     = '0;
        en_nxt    = 1'b1;
        addr_nxt  = start_base;
        busy_nxt  = 1'b1;
        valid_nxt = 1'b0;
      end
    end
  end

  // State register and registered control outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      base         <= '0;
      k            <= '0;
      mem_en       <= 1'b0;
      mem_addr     <= '0;
      scaler_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state        <= state_nxt;
      base         <= base_nxt;
      k            <= k_nxt;
      mem_en       <= en_nxt;
      mem_addr     <= addr_nxt;
      scaler_valid <= valid_nxt;
      busy         <= busy_nxt;
    end
  end

  // Read-return pipeline: write the returning word into its channel; an abort drops in-flight reads.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_d       <= 1'b0;
      k_d        <= '0;
      scaler_vec <= '0;
    end else begin
      en_d <= mem_en && run;
      k_d  <= k;
      if (en_d && run) begin
        for (int c = 0; c < NUM_CH; c++) begin
          if (k_d == K_W'(c)) begin
            scaler_vec[c*DATA_W +: DATA_W] <= mem_dout;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_scaler_bank_loader.sv
// tb/tb_scaler_bank_loader.sv - scoreboard bench for scaler_bank_loader
module tb_scaler_bank_loader;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  // main instance: NUM_CH=4, ADDR_W=6
  logic         run_a = 1'b0, reload_a = 1'b0;
  logic [3:0]   layer_a = '0;
  logic         mem_en_a;
  logic [5:0]   mem_addr_a;
  logic [31:0]  dout_a = '0;
  logic [127:0] vec_a;
  logic         valid_a, busy_a;
  logic [31:0]  rom_ofs = 32'h1000;

  // wrap instance: NUM_CH=6, ADDR_W=4
  logic         run_w = 1'b0, reload_w = 1'b0;
  logic [3:0]   layer_w = '0;
  logic         mem_en_w;
  logic [3:0]   mem_addr_w;
  logic [31:0]  dout_w = '0;
  logic [191:0] vec_w;
  logic         valid_w, busy_w;

  // single-channel instance
  logic         run_1 = 1'b0, reload_1 = 1'b0;
  logic [3:0]   layer_1 = '0;
  logic         mem_en_1;
  logic [5:0]   mem_addr_1;
  logic [31:0]  dout_1 = '0;
  logic [31:0]  vec_1;
  logic         valid_1, busy_1;

  scaler_bank_loader #(.DATA_W(32), .NUM_CH(4), .LAYER_W(4), .ADDR_W(6)) dut (
    .clk(clk), .rst_n(rst_n), .run(run_a), .reload(reload_a), .layer_idx(layer_a),
    .mem_en(mem_en_a), .mem_addr(mem_addr_a), .mem_dout(dout_a),
    .scaler_vec(vec_a), .scaler_valid(valid_a), .busy(busy_a)
  );

  scaler_bank_loader #(.DATA_W(32), .NUM_CH(6), .LAYER_W(4), .ADDR_W(4)) dut_w (
    .clk(clk), .rst_n(rst_n), .run(run_w), .reload(reload_w), .layer_idx(layer_w),
    .mem_en(mem_en_w), .mem_addr(mem_addr_w), .mem_dout(dout_w),
    .scaler_vec(vec_w), .scaler_valid(valid_w), .busy(busy_w)
  );

  scaler_bank_loader #(.DATA_W(32), .NUM_CH(1), .LAYER_W(4), .ADDR_W(6)) dut_1 (
    .clk(clk), .rst_n(rst_n), .run(run_1), .reload(reload_1), .layer_idx(layer_1),
    .mem_en(mem_en_1), .mem_addr(mem_addr_1), .mem_dout(dout_1),
    .scaler_vec(vec_1), .scaler_valid(valid_1), .busy(busy_1)
  );

  // synchronous ROM models
  always @(posedge clk) begin
    if (mem_en_a) dout_a <= rom_ofs + 32'(mem_addr_a);
    if (mem_en_w) dout_w <= 32'hA000 + 32'(mem_addr_w);
    if (mem_en_1) dout_1 <= 32'hB000 + 32'(mem_addr_1);
  end

  logic [5:0]   addr_q[$];
  logic [127:0] vec_q[$];
  logic [3:0]   addr_wq[$];
  logic [5:0]   addr_1q[$];

  // scoreboard monitor for the main instance
  logic [5:0]   mon_ea;
  logic [127:0] mon_ev;
  logic         prev_valid_a = 1'b0;
  always @(negedge clk) begin
    if (mem_en_a === 1'b1) begin
      n_checks++;
      if (addr_q.size() == 0) begin
        $display("FAIL mem_addr_unexpected got %0d want no read", mem_addr_a);
      end else begin
        mon_ea = addr_q.pop_front();
        if (mem_addr_a !== mon_ea) $display("FAIL mem_addr got %0d want %0d", mem_addr_a, mon_ea);
        else n_pass++;
      end
    end
    if (valid_a === 1'b1 && prev_valid_a !== 1'b1) begin
      n_checks++;
      if (vec_q.size() == 0) begin
        $display("FAIL valid_unexpected got vec %h want no valid", vec_a);
      end else begin
        mon_ev = vec_q.pop_front();
        if (vec_a !== mon_ev) $display("FAIL scaler_vec got %h want %h", vec_a, mon_ev);
        else n_pass++;
      end
    end
    prev_valid_a = valid_a;
  end

  task automatic push_fetch(input logic [5:0] base, input int n);
    for (int k = 0; k < n; k++) addr_q.push_back(6'(base + 6'(k)));
  endtask

  task automatic wait_valid(input int glitch, output int lat, output int bc, output int ec, output logic v0);
    lat = -1; bc = 0; ec = 0; v0 = 1'bx;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 0) begin v0 = valid_a; reload_a = 1'b0; end
      if (busy_a) bc++;
      if (mem_en_a) ec++;
      if (i == glitch) begin reload_a = 1'b1; layer_a = 4'd5; end
      else if (i == glitch + 1) reload_a = 1'b0;
      if (valid_a) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    int en_seen;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mem_en_a, mem_addr_a, valid_a, busy_a, vec_a} !== '0)
      $display("FAIL reset_values got %h want 0", {mem_en_a, mem_addr_a, valid_a, busy_a, vec_a});
    else n_pass++;
    rst_n = 1'b1;
    @(negedge clk);
    layer_a = 4'd1; run_a = 1'b1;
    push_fetch(6'd4, 2);
    @(negedge clk);
    @(negedge clk);
    n_checks++;
    if (busy_a !== 1'b1) $display("FAIL busy_mid_fetch got %b want 1", busy_a); else n_pass++;
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({mem_en_a, mem_addr_a, valid_a, busy_a, vec_a} !== '0)
      $display("FAIL async_reset got %h want 0", {mem_en_a, mem_addr_a, valid_a, busy_a, vec_a});
    else n_pass++;
    @(negedge clk);
    run_a = 1'b0; rst_n = 1'b1;
    en_seen = 0;
    repeat (4) begin @(negedge clk); if (mem_en_a) en_seen++; end
    n_checks++;
    if (en_seen !== 0) $display("FAIL post_reset_mem_en got %0d want 0", en_seen); else n_pass++;
    n_checks++;
    if (busy_a !== 1'b0) $display("FAIL post_reset_busy got %b want 0", busy_a); else n_pass++;
  endtask

  task automatic test_basic();
    int lat, bc, ec; logic v0;
    logic [127:0] ev;
    ev = {32'h100B, 32'h100A, 32'h1009, 32'h1008};
    rom_ofs = 32'h1000; layer_a = 4'd2;
    push_fetch(6'd8, 4); vec_q.push_back(ev);
    run_a = 1'b1;
    wait_valid(-1, lat, bc, ec, v0);
    n_checks++; if (lat !== 5) $display("FAIL basic_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (bc !== 5) $display("FAIL basic_busy_cycles got %0d want 5", bc); else n_pass++;
    n_checks++; if (ec !== 4) $display("FAIL basic_read_cycles got %0d want 4", ec); else n_pass++;
    n_checks++; if (vec_a !== ev) $display("FAIL basic_vec got %h want %h", vec_a, ev); else n_pass++;
  endtask

  task automatic test_reload();
    int lat, bc, ec; logic v0;
    logic [127:0] ev;
    ev = {32'h200F, 32'h200E, 32'h200D, 32'h200C};
    rom_ofs = 32'h2000; layer_a = 4'd3;
    push_fetch(6'd12, 4); vec_q.push_back(ev);
    reload_a = 1'b1;
    wait_valid(-1, lat, bc, ec, v0);
    n_checks++; if (v0 !== 1'b0) $display("FAIL reload_valid_drop got %b want 0", v0); else n_pass++;
    n_checks++; if (lat !== 5) $display("FAIL reload_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (vec_a !== ev) $display("FAIL reload_vec got %h want %h", vec_a, ev); else n_pass++;
  endtask

  task automatic test_reload_in_fetch();
    int lat, bc, ec, en_seen; logic v0;
    logic [127:0] ev;
    ev = {32'h3007, 32'h3006, 32'h3005, 32'h3004};
    rom_ofs = 32'h3000; layer_a = 4'd1;
    push_fetch(6'd4, 4); vec_q.push_back(ev);
    reload_a = 1'b1;
    wait_valid(1, lat, bc, ec, v0);
    n_checks++; if (lat !== 5) $display("FAIL fetch_reload_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (ec !== 4) $display("FAIL fetch_reload_reads got %0d want 4", ec); else n_pass++;
    en_seen = 0;
    repeat (3) begin @(negedge clk); if (mem_en_a) en_seen++; end
    n_checks++;
    if ({en_seen, valid_a} !== {32'd0, 1'b1})
      $display("FAIL fetch_reload_settle got reads=%0d valid=%b want reads=0 valid=1", en_seen, valid_a);
    else n_pass++;
  endtask

  task automatic test_abort();
    logic [127:0] ev;
    ev = {32'h3007, 32'h3006, 32'h3005, 32'h4000};
    run_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({valid_a, busy_a} !== 2'b00) $display("FAIL abort_ready got %b want 00", {valid_a, busy_a}); else n_pass++;
    rom_ofs = 32'h4000; layer_a = 4'd0;
    push_fetch(6'd0, 3);
    run_a = 1'b1;
    repeat (3) @(negedge clk);
    run_a = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({mem_en_a, valid_a, busy_a} !== 3'b000)
      $display("FAIL abort_fetch got %b want 000", {mem_en_a, valid_a, busy_a});
    else n_pass++;
    repeat (2) @(negedge clk);
    n_checks++;
    if (vec_a !== ev) $display("FAIL abort_vec got %h want %h", vec_a, ev); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int lat, bc, ec, en_seen; logic v0;
    logic [127:0] ev;
    ev = {32'h5013, 32'h5012, 32'h5011, 32'h5010};
    rom_ofs = 32'h5000; layer_a = 4'd4;
    push_fetch(6'd16, 4); vec_q.push_back(ev);
    run_a = 1'b1;
    wait_valid(-1, lat, bc, ec, v0);
    n_checks++; if (lat !== 5) $display("FAIL override_setup_latency got %0d want 5", lat); else n_pass++;
    run_a = 1'b0; reload_a = 1'b1;
    @(negedge clk);
    reload_a = 1'b0;
    n_checks++;
    if ({mem_en_a, valid_a, busy_a} !== 3'b000)
      $display("FAIL override_run_low got %b want 000", {mem_en_a, valid_a, busy_a});
    else n_pass++;
    en_seen = 0;
    repeat (3) begin @(negedge clk); if (mem_en_a) en_seen++; end
    n_checks++; if (en_seen !== 0) $display("FAIL override_idle_reads got %0d want 0", en_seen); else n_pass++;
    ev = {32'h6003, 32'h6002, 32'h6001, 32'h6000};
    rom_ofs = 32'h6000; layer_a = 4'd0;
    push_fetch(6'd0, 4); vec_q.push_back(ev);
    run_a = 1'b1;
    wait_valid(-1, lat, bc, ec, v0);
    n_checks++; if (lat !== 5) $display("FAIL restart_latency got %0d want 5", lat); else n_pass++;
    n_checks++; if (vec_a !== ev) $display("FAIL restart_vec got %h want %h", vec_a, ev); else n_pass++;
  endtask

  task automatic test_wrap();
    int lat;
    logic [3:0]   ea;
    logic [191:0] ev;
    for (int k = 0; k < 6; k++) begin
      addr_wq.push_back(4'(2 + k));
      ev[k*32 +: 32] = 32'hA000 + 32'(2 + k);
    end
    layer_w = 4'd3; run_w = 1'b1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en_w) begin
        n_checks++;
        if (addr_wq.size() == 0) $display("FAIL wrap_addr_unexpected got %0d want no read", mem_addr_w);
        else begin
          ea = addr_wq.pop_front();
          if (mem_addr_w !== ea) $display("FAIL wrap_addr got %0d want %0d", mem_addr_w, ea); else n_pass++;
        end
      end
      if (valid_w) begin lat = i; break; end
    end
    n_checks++; if (lat !== 7) $display("FAIL wrap_latency got %0d want 7", lat); else n_pass++;
    n_checks++; if (vec_w !== ev) $display("FAIL wrap_vec got %h want %h", vec_w, ev); else n_pass++;
    n_checks++; if (addr_wq.size() !== 0) $display("FAIL wrap_reads_left got %0d want 0", addr_wq.size()); else n_pass++;
  endtask

  task automatic test_one_channel();
    int lat;
    logic [5:0] ea;
    addr_1q.push_back(6'd5);
    layer_1 = 4'd5; run_1 = 1'b1;
    lat = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (mem_en_1) begin
        n_checks++;
        if (addr_1q.size() == 0) $display("FAIL one_addr_unexpected got %0d want no read", mem_addr_1);
        else begin
          ea = addr_1q.pop_front();
          if (mem_addr_1 !== ea) $display("FAIL one_addr got %0d want %0d", mem_addr_1, ea); else n_pass++;
        end
      end
      if (valid_1) begin lat = i; break; end
    end
    n_checks++; if (lat !== 2) $display("FAIL one_latency got %0d want 2", lat); else n_pass++;
    n_checks++; if (vec_1 !== 32'hB005) $display("FAIL one_vec got %h want b005", vec_1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_reload();
    test_reload_in_fetch();
    test_abort();
    test_back_to_back();
    test_wrap();
    test_one_channel();
    repeat (2) @(negedge clk);
    n_checks++;
    if (addr_q.size() !== 0 || vec_q.size() !== 0)
      $display("FAIL scoreboard_drain got addr=%0d vec=%0d want 0 0", addr_q.size(), vec_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/scaler_bank_loader.md
# scaler_bank_loader

Parametrised multi-channel scaler loader for the TNN accelerator datapath. When a layer starts, it fetches NUM_CH per-channel scale words for that layer from a synchronous single-port scaler ROM, one read per cycle. It packs the words into a held output vector and flags it valid. It supports layer selection, mid-layer reload and abort. The post-accumulation scaling stage consumes `scaler_vec` directly.

## Interface
- DATA_W, 32, width of one scale word
- NUM_CH, 4, scale words per layer (≥1)
- LAYER_W, 4, width of layer index
- ADDR_W, 6, scaler ROM address width
- clk  in  1  clock, all logic on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- run  in  1  level; high while the layer is active (layer state)
- reload  in  1  one-cycle pulse; refetch using current layer_idx
- layer_idx  in  LAYER_W  layer whose scalers are fetched
- mem_en  out  1  ROM read enable
- mem_addr  out  ADDR_W  ROM address
- mem_dout  in  DATA_W  ROM data, valid one cycle after the mem_en cycle
- scaler_vec  out  NUM_CH*DATA_W  channel k occupies bits [k*DATA_W +: DATA_W]
- scaler_valid  out  1  high when all NUM_CH words of the current fetch are loaded
- busy  out  1  fetch in progress (FETCH or DRAIN)

## Operation
- All outputs are registered. Reset values: mem_en=0, mem_addr=0, scaler_vec=0, scaler_valid=0, busy=0, FSM=IDLE.
- FSM has four states: IDLE, FETCH, DRAIN, READY.
- IDLE: when run=1 is sampled, latch base = layer_idx*NUM_CH (truncated to ADDR_W) and go to FETCH.
- FETCH:
  - Issue NUM_CH reads on consecutive cycles: mem_en=1, mem_addr=base+k for k=0..NUM_CH-1. The address wraps modulo 2^ADDR_W.
  - After the read with k=NUM_CH-1 is issued, go to DRAIN.
- Capture pipeline: mem_en and k are delayed one cycle (en_d, k_d). On every edge where en_d=1, mem_dout is written into channel k_d. Other channels are untouched.
- DRAIN: on the edge that captures k_d=NUM_CH-1, set scaler_valid=1 and go to READY.
- READY: mem_en=0 and scaler_vec holds its value.
  - If reload=1 is sampled: latch a new base from layer_idx, clear scaler_valid on the same edge, and go to FETCH.
  - During the refetch, channels keep their old values until overwritten.
- Abort: if run=0 is sampled in any state, the next edge sets FSM=IDLE, mem_en=0, busy=0 and scaler_valid=0.
  - en_d is also cleared, so a read already in flight is discarded.
  - scaler_vec keeps its contents; it is not zeroed.
- Precedence: run=0 overrides reload. reload in IDLE, FETCH or DRAIN is ignored. layer_idx is sampled only at fetch start.
- busy=1 exactly while FSM is FETCH or DRAIN.
- NUM_CH=1: FETCH lasts one cycle, then DRAIN follows.

## Timing
- E0 is the edge that samples run=1 in IDLE (or reload=1 in READY).
- mem_en is high between edges E0 and E_NUM_CH, i.e. NUM_CH cycles. Channel k is captured at edge E(k+2).
- scaler_valid rises at E(NUM_CH+1), so fetch latency is NUM_CH+1 cycles. For NUM_CH=4, valid rises at E5.
- busy rises at E0 and falls at E(NUM_CH+1).
- Back-to-back layers: run must be low for at least one sampled edge to start a new fetch from IDLE. Otherwise use reload.
- No combinational path from any input to any output.

## Test plan
- Reset mid-fetch: assert rst_n=0 during FETCH -> all outputs return to their reset values asynchronously. After release, no mem_en until run is sampled high.
- Basic load, NUM_CH=4, layer_idx=2:
  - Stimulus: ROM[a]=0x1000+a; run rises.
  - Required: mem_addr 8,9,10,11 on 4 consecutive cycles; scaler_valid at E5; scaler_vec = {0x100B,0x100A,0x1009,0x1008}.
- Abort: drop run at E2 -> mem_en=0 and scaler_valid=0 after the next edge. The word returning at E3 is not written. Channels 1..3 retain their prior values.
- Reload in READY with layer_idx=3 -> scaler_valid falls at E0, addresses 12..15 are issued, valid returns at E5 with the new words.
- Ignored and overridden controls:
  - reload pulsed during FETCH -> ignored; a single fetch of 4 reads.
  - reload and run=0 on the same edge -> FSM goes to IDLE.
- Wrap-around, ADDR_W=4, layer_idx=3, NUM_CH=6 -> base=18 truncates to 2; addresses 2..7 are issued. Also run NUM_CH=1: valid 2 cycles after E0.
